// File: rtl/apb_req_arbiter_if.sv
// Request-side and APB-side signal bundle for apb_req_arbiter.
// Optional macro APB_ARB_PREADY_EN adds the slave pready input.
interface apb_req_arbiter_if #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32
);
   // Handshake: a requester raises req[i] with its fields and holds it until
   // ack[i] pulses for one cycle; that pulse retires exactly one transaction.
   logic [1:0]             req;
   logic [1:0]             reqWrite;
   logic [2*addrWidth-1:0] reqAddr;
   logic [2*dataWidth-1:0] reqWdata;
   logic [1:0]             ack;
   logic [dataWidth-1:0]   rdata;
   logic                   busy;
   logic                   psel;
   logic                   penable;
   logic                   pwrite;
   logic [addrWidth-1:0]   paddr;
   logic [dataWidth-1:0]   pwdata;
   logic [dataWidth-1:0]   prdata;
`ifdef APB_ARB_PREADY_EN
   logic                   pready;

   modport master (
      input  req, reqWrite, reqAddr, reqWdata, prdata, pready,
      output ack, rdata, busy, psel, penable, pwrite, paddr, pwdata
   );
   modport slave (
      output req, reqWrite, reqAddr, reqWdata, prdata, pready,
      input  ack, rdata, busy, psel, penable, pwrite, paddr, pwdata
   );
`else
   modport master (
      input  req, reqWrite, reqAddr, reqWdata, prdata,
      output ack, rdata, busy, psel, penable, pwrite, paddr, pwdata
   );
   modport slave (
      output req, reqWrite, reqAddr, reqWdata, prdata,
      input  ack, rdata, busy, psel, penable, pwrite, paddr, pwdata
   );
`endif
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving one APB master port.
// Macro APB_ARB_PREADY_EN: adds pready wait states in ACCESS.
module apb_req_arbiter #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   apb_req_arbiter_if.master bus,
   output logic [1:0]        dbg_state
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      ACCESS   = 2'd2,
      COMPLETE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           ack_q, ack_d;
   logic                 grant_q, grant_d;
   logic                 last_q, last_d;
   logic                 write_q, write_d;
   logic [addrWidth-1:0] addr_q, addr_d;
   logic [dataWidth-1:0] wdata_q, wdata_d;
   logic [dataWidth-1:0] rdata_q, rdata_d;
   logic [1:0]           elig;
   logic                 grant_valid;
   logic                 grant_idx;
   logic                 access_done;

`ifdef APB_ARB_PREADY_EN
   assign access_done = bus.pready;
`else
   assign access_done = 1'b1;
`endif

   // A requester sitting in its ack cycle is not eligible, so a held req
   // cannot be served twice for one transaction.
   always_comb begin
      elig        = bus.req & ~ack_q;
      grant_valid = |elig;
      grant_idx   = (elig == 2'b11) ? ~last_q : elig[1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (grant_valid) state_d = SETUP;
         SETUP:    state_d = ACCESS;
         ACCESS:   if (access_done) state_d = COMPLETE;
         COMPLETE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_q   <= 2'b00;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         ack_q   <= ack_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Request fields are captured once at grant; later requester edits are ignored.
   always_comb begin
      ack_d   = 2'b00;
      grant_d = grant_q;
      last_d  = last_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (state_q == IDLE && grant_valid) begin
         grant_d = grant_idx;
         last_d  = grant_idx;
         write_d = bus.reqWrite[grant_idx];
         addr_d  = grant_idx ? bus.reqAddr[2*addrWidth-1:addrWidth]
                             : bus.reqAddr[addrWidth-1:0];
         wdata_d = grant_idx ? bus.reqWdata[2*dataWidth-1:dataWidth]
                             : bus.reqWdata[dataWidth-1:0];
      end
      if (state_q == COMPLETE) begin
         ack_d[grant_q] = 1'b1;
         if (!write_q) rdata_d = bus.prdata;
      end
   end

   always_comb begin
      bus.psel    = (state_q == SETUP) || (state_q == ACCESS);
      bus.penable = (state_q == ACCESS);
      bus.busy    = (state_q != IDLE);
      bus.pwrite  = write_q;
      bus.paddr   = addr_q;
      bus.pwdata  = wdata_q;
      bus.ack     = ack_q;
      bus.rdata   = rdata_q;
      dbg_state   = state_q;
   end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed vector table, corner sequences and a
// randomized run checked every cycle against a transaction-schedule model.
module tb_apb_req_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int PW = 6 + AW + 2*DW;

   typedef struct {
      bit         do_reset;
      logic [1:0] req;
      logic [1:0] wr;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0] first_ack;
      logic [31:0] exp_rdata;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    dbg_state;
   logic          pready_ok;
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b1;
   logic [PW-1:0] exp_q[$];
   bit [31:0]     mem[256];
   bit            mem_wr[256];
   bit [31:0]     ref_mem[256];
   bit            ref_wr[256];

   apb_req_arbiter_if #(.addrWidth(AW), .dataWidth(DW)) bus();

   apb_req_arbiter #(.addrWidth(AW), .dataWidth(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

`ifdef APB_ARB_PREADY_EN
   assign pready_ok = bus.pready;
`else
   assign pready_ok = 1'b1;
`endif

   // Zero-wait APB slave; unwritten locations read as 0x1000 + address.
   assign bus.prdata = mem_wr[bus.paddr[7:0]] ? mem[bus.paddr[7:0]]
                                              : (32'h1000 + {24'h0, bus.paddr[7:0]});

   always @(posedge clk) begin
      if (bus.psel && bus.penable && bus.pwrite && pready_ok) begin
         mem[bus.paddr[7:0]]    <= bus.pwdata;
         mem_wr[bus.paddr[7:0]] <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(int i, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
      bus.req[i]               = r;
      bus.reqWrite[i]          = w;
      bus.reqAddr[i*AW +: AW]  = a;
      bus.reqWdata[i*DW +: DW] = d;
   endtask

   function automatic logic [PW-1:0] pack(logic [1:0] a, logic ps, logic pe, logic bz,
                                          logic pw, logic [AW-1:0] pa,
                                          logic [DW-1:0] wd, logic [DW-1:0] rd);
      return {a, ps, pe, bz, pw, pa, wd, rd};
   endfunction

   // Model: a granted transaction is k cycles old (1 = address phase, 2 = data
   // phase until ready, 3 = completion); it retires with an ack the cycle after.
   task automatic monitor_loop();
      bit            m_active = 1'b0;
      int            m_age = 0;
      int            m_who = 0;
      bit            m_last = 1'b1;
      bit            m_write = 1'b0;
      logic [AW-1:0] m_addr = '0;
      logic [DW-1:0] m_wdata = '0;
      logic [DW-1:0] m_rdata = '0;
      logic [1:0]    m_ack = 2'b00;
      logic [1:0]    new_ack;
      logic [1:0]    elig;
      bit            rdy;
      logic [PW-1:0] exp_w;
      logic [PW-1:0] act_w;
      while (mon_en) begin
         @(posedge clk);
         rdy     = pready_ok;
         new_ack = 2'b00;
         if (m_active && m_age == 2 && rdy && m_write) begin
            ref_mem[m_addr[7:0]] = m_wdata;
            ref_wr[m_addr[7:0]]  = 1'b1;
         end
         if (!rst_n) begin
            m_active = 1'b0; m_age = 0; m_last = 1'b1; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_ack = 2'b00;
         end else begin
            if (m_active) begin
               if (m_age == 3) begin
                  new_ack[m_who] = 1'b1;
                  if (!m_write)
                     m_rdata = ref_wr[m_addr[7:0]] ? ref_mem[m_addr[7:0]]
                                                   : (32'h1000 + {24'h0, m_addr[7:0]});
                  m_active = 1'b0;
               end else if (m_age == 2) begin
                  if (rdy) m_age = 3;
               end else begin
                  m_age = 2;
               end
            end else begin
               elig = bus.req & ~m_ack;
               if (elig != 2'b00) begin
                  if (elig == 2'b11) m_who = m_last ? 0 : 1;
                  else               m_who = elig[1] ? 1 : 0;
                  m_last   = (m_who == 1);
                  m_write  = bus.reqWrite[m_who];
                  m_addr   = bus.reqAddr[m_who*AW +: AW];
                  m_wdata  = bus.reqWdata[m_who*DW +: DW];
                  m_active = 1'b1;
                  m_age    = 1;
               end
            end
            m_ack = new_ack;
         end
         exp_q.push_back(pack(m_ack, m_active && (m_age == 1 || m_age == 2),
                              m_active && m_age == 2, m_active, m_write,
                              m_addr, m_wdata, m_rdata));
         #1;
         act_w = pack(bus.ack, bus.psel, bus.penable, bus.busy, bus.pwrite,
                      bus.paddr, bus.pwdata, bus.rdata);
         exp_w = exp_q.pop_front();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, act_w, exp_w);
         end
      end
   endtask

   initial begin
      vec_t       vt[9];
      int         f;
      int         n_ack;
      logic [1:0] other;
      bus.req = 2'b00; bus.reqWrite = 2'b00; bus.reqAddr = '0; bus.reqWdata = '0;
`ifdef APB_ARB_PREADY_EN
      bus.pready = 1'b1;
`endif
      fork
         monitor_loop();
      join_none

      rst_n = 1'b0;
      tick(); tick();
      chk("reset_psel_penable", 64'({bus.psel, bus.penable}), 64'h0);
      chk("reset_pwrite", 64'(bus.pwrite), 64'h0);
      chk("reset_paddr", 64'(bus.paddr), 64'h0);
      chk("reset_pwdata", 64'(bus.pwdata), 64'h0);
      chk("reset_ack", 64'(bus.ack), 64'h0);
      chk("reset_rdata", 64'(bus.rdata), 64'h0);
      chk("reset_busy", 64'(bus.busy), 64'h0);
      chk("reset_state", 64'(dbg_state), 64'h0);
      rst_n = 1'b1;

      vt[0] = '{1'b0, 2'b01, 2'b01, 8'h02, 8'h00, 32'h10, 32'h0,  2'b01, 32'h0};
      vt[1] = '{1'b0, 2'b01, 2'b00, 8'h02, 8'h00, 32'h0,  32'h0,  2'b01, 32'h10};
      vt[2] = '{1'b0, 2'b01, 2'b01, 8'h03, 8'h00, 32'h55, 32'h0,  2'b01, 32'h10};
      vt[3] = '{1'b1, 2'b11, 2'b11, 8'h04, 8'h08, 32'h20, 32'h10, 2'b01, 32'h0};
      vt[4] = '{1'b0, 2'b11, 2'b11, 8'h04, 8'h08, 32'h21, 32'h11, 2'b01, 32'h0};
      vt[5] = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 32'h0,  32'h0,  2'b01, 32'h11};
      vt[6] = '{1'b0, 2'b10, 2'b00, 8'h00, 8'h04, 32'h0,  32'h0,  2'b10, 32'h21};
      vt[7] = '{1'b0, 2'b11, 2'b10, 8'h02, 8'h02, 32'h0,  32'h77, 2'b01, 32'h10};
      vt[8] = '{1'b0, 2'b10, 2'b00, 8'h00, 8'h03, 32'h0,  32'h0,  2'b10, 32'h55};

      for (int v = 0; v < 9; v++) begin
         if (vt[v].do_reset) begin
            rst_n = 1'b0; tick(); rst_n = 1'b1;
         end
         drive(0, vt[v].req[0], vt[v].wr[0], {24'h0, vt[v].a0}, vt[v].d0);
         drive(1, vt[v].req[1], vt[v].wr[1], {24'h0, vt[v].a1}, vt[v].d1);
         f     = vt[v].first_ack[1] ? 1 : 0;
         other = (f == 1) ? 2'b01 : 2'b10;
         tick();
         chk("vec_setup_ctrl", 64'({bus.psel, bus.penable}), 64'h2);
         chk("vec_setup_paddr", 64'(bus.paddr), 64'((f == 1) ? vt[v].a1 : vt[v].a0));
         chk("vec_setup_pwrite", 64'(bus.pwrite), 64'(vt[v].wr[f]));
         if (vt[v].wr[f])
            chk("vec_setup_pwdata", 64'(bus.pwdata), 64'((f == 1) ? vt[v].d1 : vt[v].d0));
         // Scribble over the granted requester's fields mid-transaction.
         bus.reqAddr[f*AW +: AW]  = 32'hFFFF_FFF0;
         bus.reqWdata[f*DW +: DW] = 32'hDEAD_BEEF;
         bus.reqWrite[f]          = ~vt[v].wr[f];
         tick();
         chk("vec_access_ctrl", 64'({bus.psel, bus.penable}), 64'h3);
         chk("vec_access_paddr", 64'(bus.paddr), 64'((f == 1) ? vt[v].a1 : vt[v].a0));
         tick();
         chk("vec_complete_ctrl", 64'({bus.psel, bus.penable, bus.ack}), 64'h0);
         tick();
         chk("vec_first_ack", 64'(bus.ack), 64'(vt[v].first_ack));
         bus.req[f] = 1'b0;
         if (vt[v].req[1-f]) begin
            tick(); tick(); tick(); tick();
            chk("vec_second_ack", 64'(bus.ack), 64'(other));
            bus.req[1-f] = 1'b0;
         end
         tick();
         chk("vec_rdata", 64'(bus.rdata), 64'(vt[v].exp_rdata));
      end

      // Held request must not be re-granted in its own ack cycle.
      drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
      tick(); tick(); tick(); tick();
      chk("held_ack", 64'(bus.ack), 64'h2);
      tick();
      chk("held_no_regrant", 64'({bus.busy, bus.psel, bus.ack}), 64'h0);
      tick();
      chk("held_regrant", 64'({bus.psel, bus.penable}), 64'h2);
      n_ack = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.ack != 2'b00) begin
            n_ack++;
            bus.req[1] = 1'b0;
         end
      end
      chk("held_one_ack", 64'(n_ack), 64'h1);

      // Reset during ACCESS aborts; the still-held request is served afterwards.
      drive(0, 1'b1, 1'b0, 32'h02, 32'h0);
      tick(); tick();
      chk("rst_in_access", 64'(bus.penable), 64'h1);
      rst_n = 1'b0;
      tick();
      chk("rst_abort_bus", 64'({bus.psel, bus.penable, bus.ack, bus.busy}), 64'h0);
      chk("rst_abort_rdata", 64'(bus.rdata), 64'h0);
      rst_n = 1'b1;
      n_ack = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus.ack != 2'b00) n_ack++;
      end
      chk("rst_no_early_ack", 64'(n_ack), 64'h0);
      tick();
      chk("rst_regrant_ack", 64'(bus.ack), 64'h1);
      chk("rst_regrant_rdata", 64'(bus.rdata), 64'h77);
      bus.req[0] = 1'b0;
      tick();

`ifdef APB_ARB_PREADY_EN
      drive(0, 1'b1, 1'b0, 32'h03, 32'h0);
      tick();
      bus.pready = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk("wait_penable", 64'({bus.psel, bus.penable}), 64'h3);
         chk("wait_paddr", 64'(bus.paddr), 64'h3);
         if (k == 5) bus.pready = 1'b1;
      end
      tick();
      chk("wait_complete", 64'({bus.penable, bus.ack}), 64'h0);
      tick();
      chk("wait_ack", 64'(bus.ack), 64'h1);
      chk("wait_rdata", 64'(bus.rdata), 64'h55);
      bus.req[0] = 1'b0;
      tick();
`endif

      for (int c = 0; c < 400; c++) begin
         tick();
         rst_n = ($urandom_range(0, 99) != 0);
`ifdef APB_ARB_PREADY_EN
         bus.pready = ($urandom_range(0, 3) != 0);
`endif
         for (int i = 0; i < 2; i++) begin
            if (bus.ack[i]) begin
               if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
               else drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end else if (!bus.req[i]) begin
               if ($urandom_range(0, 2) == 0)
                  drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
               drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
         end
      end

      bus.req = 2'b00;
      rst_n   = 1'b1;
`ifdef APB_ARB_PREADY_EN
      bus.pready = 1'b1;
`endif
      for (int k = 0; k < 8; k++) tick();
      mon_en = 1'b0;
      tick(); tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
